parallel_mac_matrix_multiplier: RTL and testbench
=================================================

PARALLEL_MAC_MATRIX_MULTIPLIER -- requirements
Module: parallel_mac_matrix_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 8: square matrix dimension.
REQ-002 The block SHALL have parameter P, default 4: MAC lane count; N mod P SHALL be 0.
REQ-003 The block SHALL have parameter W, default 16: element and result width.
REQ-004 The block SHALL have derived ACC_W = 2*W + clog2(N) and IW = clog2(N), minimum 1.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port wr_en, input, 1: operand write strobe.
REQ-008 Port wr_sel, input, 1: 0 = matrix A, 1 = matrix B.
REQ-009 Port wr_i, wr_j, input, IW each: operand row and column.
REQ-010 Port wr_data, input, W: operand value.
REQ-011 Port start, input, 1: single-cycle start request.
REQ-012 Port signed_mode, input, 1: 1 = two's-complement arithmetic, 0 = unsigned.
REQ-013 Port busy, output, 1: computation in progress.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port rd_i, rd_j, input, IW each: result row and column.
REQ-016 Port rd_data, output, W: registered result element R[rd_i][rd_j].

Function
REQ-017 Storage SHALL be A, B and R, each N x N elements of W bits.
REQ-018 A write with wr_en=1 in IDLE and both indices < N SHALL update the selected element on that edge; out-of-range or non-IDLE writes SHALL be ignored.
REQ-019 States SHALL be IDLE, MAC, WB, DONE.
REQ-020 IDLE to MAC SHALL occur on start=1; signed_mode SHALL be sampled then and held for the run; row r=0, group g=0, k=0; all P accumulators SHALL be cleared.
REQ-021 In MAC, lane l SHALL add A[r][k]*B[k][g*P+l] to its ACC_W accumulator; k increments; after k=N-1 the state SHALL go to WB.
REQ-022 In WB, lane l SHALL write the converted accumulator to R[r][g*P+l] and clear the accumulator; then g increments, wrapping to 0 with r increment; the state SHALL return to MAC, or go to DONE after r=N-1, g=N/P-1.
REQ-023 DONE SHALL last one cycle with done=1 and SHALL then go to IDLE.
REQ-024 busy SHALL be 1 in MAC and WB only.
REQ-025 A run SHALL take exactly N*(N/P)*(N+1) busy cycles, which is 144 at the defaults.
REQ-026 start while not in IDLE SHALL be ignored.
REQ-027 Products SHALL be 2W bits, signed or unsigned per the sampled mode; accumulation SHALL be ACC_W bits with no overflow.
REQ-028 rd_data SHALL register R[rd_i][rd_j] one cycle after the indices are presented, and SHALL return 0 for an out-of-range index.
REQ-029 Reads during a run SHALL return the current stored contents, which may be old or partially updated.
REQ-030 R SHALL NOT be cleared between runs except by reset; A and B SHALL persist across runs.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and set busy=0, done=0 and rd_data=0.
REQ-032 rst=1 SHALL zero A, B, R and all accumulators and counters, including when asserted mid-run; the aborted run SHALL NOT pulse done.

Configuration
REQ-033 With macro MATMUL_SATURATE_EN defined, WB SHALL clamp the accumulator to the W-bit range: [-2^(W-1), 2^(W-1)-1] signed, or [0, 2^W-1] unsigned.
REQ-034 Without MATMUL_SATURATE_EN, WB SHALL store accumulator bits [W-1:0], wrapping on overflow.

Verification
REQ-035 Bench: A=identity, B[i][j]=i*8+j, unsigned, start -> R equals B; done pulses exactly 144 cycles after busy rises.
REQ-036 Bench: A=B all 1, unsigned -> every R element = 8.
REQ-037 Bench: A all 0xFFFF, B all 0x0002, signed_mode=1 -> every R = 0xFFF0 (-16).
REQ-038 Bench: A all 0x4000, B all 0x0004, unsigned -> R = 0x0000 without the macro, 0xFFFF with MATMUL_SATURATE_EN.
REQ-039 Bench: start and a wr_en write issued at cycle 10 of a run -> both ignored, the run completes unchanged and the operand is not modified.
REQ-040 Bench: rst asserted at cycle 50 of a run -> busy=0 at once, no done pulse, all rd_data reads return 0, and a new start completes correctly.

Source files
------------

// File: rtl/parallel_mac_matrix_multiplier.sv
// parallel_mac_matrix_multiplier: N x N matrix product R = A*B using P parallel MAC lanes.
// Define MATMUL_SATURATE_EN to clamp results to W bits instead of wrapping.
module parallel_mac_matrix_multiplier #(
    parameter int N = 8,
    parameter int P = 4,
    parameter int W = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int ACC_W = 2 * W + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_i,
    input  logic [IW-1:0] wr_j,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    input  logic          signed_mode,
    output logic          busy,
    output logic          done,
    input  logic [IW-1:0] rd_i,
    input  logic [IW-1:0] rd_j,
    output logic [W-1:0]  rd_data
);
    localparam int NG = N / P;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] mat_a [N][N];
    logic [W-1:0] mat_b [N][N];
    logic [W-1:0] mat_r [N][N];
    logic [ACC_W-1:0] acc [P];
    logic [ACC_W-1:0] prod [P];
    logic [2*W-1:0] b_ext [P];
    logic [2*W-1:0] p2 [P];
    logic [W-1:0] res [P];
    logic [IW-1:0] col [P];
    logic [2*W-1:0] a_ext;
    logic [IW-1:0] row, kk;
    logic [GW-1:0] grp;
    logic sm, last_k, last_g, last_blk;
`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'(1) << (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
    localparam logic [ACC_W-1:0] UMAX = ACC_W'((64'(1) << W) - 1);
    function automatic logic [W-1:0] clamp(input logic [ACC_W-1:0] v, input logic s);
        if (s)
            return ($signed(v) > SMAX) ? {1'b0, {(W-1){1'b1}}} :
                   ($signed(v) < SMIN) ? {1'b1, {(W-1){1'b0}}} : v[W-1:0];
        return (v > UMAX) ? {W{1'b1}} : v[W-1:0];
    endfunction
`endif
    assign last_k = 32'(kk) == N - 1;
    assign last_g = 32'(grp) == NG - 1;
    assign last_blk = last_g && 32'(row) == N - 1;
    always_comb begin
        a_ext = sm ? {{W{mat_a[row][kk][W-1]}}, mat_a[row][kk]} : {{W{1'b0}}, mat_a[row][kk]};
        for (int l = 0; l < P; l++) begin
            col[l] = IW'(32'(grp) * P + l);
            b_ext[l] = sm ? {{W{mat_b[kk][col[l]][W-1]}}, mat_b[kk][col[l]]}
                          : {{W{1'b0}}, mat_b[kk][col[l]]};
            p2[l] = a_ext * b_ext[l];
            prod[l] = sm ? ACC_W'($signed(p2[l])) : ACC_W'(p2[l]);
`ifdef MATMUL_SATURATE_EN
            res[l] = clamp(acc[l], sm);
`else
            res[l] = acc[l][W-1:0];
`endif
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_n = start ? MAC : IDLE;
            MAC: begin
                busy = 1'b1;
                state_n = last_k ? WB : MAC;
            end
            WB: begin
                busy = 1'b1;
                state_n = last_blk ? DONE : MAC;
            end
            default: begin
                done = 1'b1;
                state_n = IDLE;
            end
        endcase
    end
    // Operand/result storage, lane accumulators and the row/group/k walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    mat_a[i][j] <= '0;
                    mat_b[i][j] <= '0;
                    mat_r[i][j] <= '0;
                end
            for (int l = 0; l < P; l++) acc[l] <= '0;
            row <= '0;
            grp <= '0;
            kk <= '0;
            sm <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_data <= (32'(rd_i) < N && 32'(rd_j) < N) ? mat_r[rd_i][rd_j] : '0;
            if (state == IDLE && wr_en && 32'(wr_i) < N && 32'(wr_j) < N) begin
                if (wr_sel) mat_b[wr_i][wr_j] <= wr_data;
                else mat_a[wr_i][wr_j] <= wr_data;
            end
            if (state == IDLE && start) begin
                sm <= signed_mode;
                row <= '0;
                grp <= '0;
                kk <= '0;
                for (int l = 0; l < P; l++) acc[l] <= '0;
            end
            if (state == MAC) begin
                for (int l = 0; l < P; l++) acc[l] <= acc[l] + prod[l];
                kk <= last_k ? '0 : kk + 1'b1;
            end
            if (state == WB) begin
                for (int l = 0; l < P; l++) begin
                    mat_r[row][col[l]] <= res[l];
                    acc[l] <= '0;
                end
                grp <= last_g ? '0 : grp + 1'b1;
                row <= last_g ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: tb/tb_parallel_mac_matrix_multiplier.sv
// tb_parallel_mac_matrix_multiplier: table-driven and random checks against a plain-arithmetic model.
module tb_parallel_mac_matrix_multiplier;
    localparam int N = 8;
    localparam int P = 4;
    localparam int W = 16;
    logic clk = 0, rst = 1, wr_en = 0, wr_sel = 0, start = 0, signed_mode = 0;
    logic [2:0] wr_i = 0, wr_j = 0, rd_i = 0, rd_j = 0;
    logic [15:0] wr_data = 0;
    logic busy, done;
    logic [15:0] rd_data;
    int checks = 0, errors = 0;
    logic [15:0] ma [N][N];
    logic [15:0] mb [N][N];
    logic [15:0] mr [N][N];

    typedef struct {
        int am; logic [15:0] av;
        int bm; logic [15:0] bv;
        bit sm; bit has_k; logic [15:0] k;
    } vec_t;
    vec_t vecs[6];

    parallel_mac_matrix_multiplier #(.N(N), .P(P), .W(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_i(wr_i), .wr_j(wr_j),
        .wr_data(wr_data), .start(start), .signed_mode(signed_mode), .busy(busy),
        .done(done), .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int i, input int j, input logic [15:0] d);
        wr_en = 1; wr_sel = sel; wr_i = 3'(i); wr_j = 3'(j); wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    function automatic logic [15:0] pat(input int m, input logic [15:0] v, input int i, input int j);
        return m == 0 ? 16'(i == j) : m == 1 ? 16'(i * 8 + j) : m == 2 ? v : 16'($urandom);
    endfunction

    task automatic load(input int am, input logic [15:0] av, input int bm, input logic [15:0] bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = pat(am, av, i, j);
                wr(0, i, j, ma[i][j]);
                mb[i][j] = pat(bm, bv, i, j);
                wr(1, i, j, mb[i][j]);
            end
    endtask

    function automatic logic [15:0] conv(input longint s, input bit sm);
`ifdef MATMUL_SATURATE_EN
        if (sm) return s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
        return s > 65535 ? 16'hFFFF : 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic model(input bit sm);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int k = 0; k < N; k++)
                    s += sm ? longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]))
                            : longint'(ma[i][k]) * longint'(mb[k][j]);
                mr[i][j] = conv(s, sm);
            end
    endtask

    task automatic read_all(input string nm, input bit has_k, input logic [15:0] k);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                rd_i = 3'(i); rd_j = 3'(j);
                @(negedge clk);
                chk($sformatf("%s_r%0d%0d", nm, i, j), rd_data, mr[i][j]);
                if (has_k && (i + j == 0 || i + j == 2 * N - 2))
                    chk($sformatf("%s_const%0d%0d", nm, i, j), rd_data, k);
            end
    endtask

    // inj: busy-cycle index for the ignored start/write; rs: busy-cycle index for reset
    task automatic run(input int inj, input int rs, output int cyc, output bit dn);
        cyc = 0; dn = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        while (cyc < 1000) begin
            if (done) begin dn = 1; break; end
            if (busy) cyc++;
            if (cyc == inj) begin
                start = 1; wr_en = 1; wr_sel = 0; wr_i = 0; wr_j = 0; wr_data = 16'h1234;
            end
            if (cyc == rs) begin
                rst = 1;
                #1;
                chk("rst_busy_now", busy, 0);
                chk("rst_done_now", done, 0);
                @(negedge clk);
                rst = 0;
                return;
            end
            @(negedge clk);
            start = 0; wr_en = 0;
        end
    endtask

    task automatic full_run(input string nm, input bit sm, input bit has_k, input logic [15:0] k);
        int cyc; bit dn;
        signed_mode = sm;
        model(sm);
        run(-1, -1, cyc, dn);
        chk({nm, "_done"}, dn, 1);
        chk({nm, "_cycles"}, cyc, 144);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, done, 0);
        read_all(nm, has_k, k);
    endtask

    initial begin
        int cyc, quiet;
        bit dn;
        vecs[0] = '{0, 0, 1, 0, 0, 0, 0};
        vecs[1] = '{2, 16'h0001, 2, 16'h0001, 0, 1, 16'h0008};
        vecs[2] = '{2, 16'hFFFF, 2, 16'h0002, 1, 1, 16'hFFF0};
`ifdef MATMUL_SATURATE_EN
        vecs[3] = '{2, 16'h4000, 2, 16'h0004, 0, 1, 16'hFFFF};
`else
        vecs[3] = '{2, 16'h4000, 2, 16'h0004, 0, 1, 16'h0000};
`endif
        vecs[4] = '{3, 0, 3, 0, 1, 0, 0};
        vecs[5] = '{3, 0, 3, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 0;
        @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].am, vecs[v].av, vecs[v].bm, vecs[v].bv);
            full_run($sformatf("vec%0d", v), vecs[v].sm, vecs[v].has_k, vecs[v].k);
        end
        // start and operand write during a run must both be ignored
        load(0, 0, 1, 0);
        signed_mode = 0;
        model(0);
        run(10, -1, cyc, dn);
        chk("inj_done", dn, 1);
        chk("inj_cycles", cyc, 144);
        @(negedge clk);
        chk("inj_no_restart", busy, 0);
        read_all("inj", 0, 0);
        full_run("inj_rerun", 0, 0, 0);
        // reset mid-run aborts without done and clears all storage
        load(3, 0, 3, 0);
        signed_mode = 1;
        run(-1, 50, cyc, dn);
        quiet = 0;
        repeat (20) begin
            if (done || busy) quiet++;
            @(negedge clk);
        end
        chk("rst_quiet", quiet, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0; mb[i][j] = 0; mr[i][j] = 0;
            end
        read_all("after_rst", 0, 0);
        load(0, 0, 1, 0);
        full_run("post_rst", 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
